// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the memory round-robin arbiter.
// Controller command encoding, default widths and the read-tracking tag live here.
package mem_arb_pkg;

  localparam logic MEM_WRITE = 1'b0;
  localparam logic MEM_READ  = 1'b1;

  localparam int DEFAULT_N = 32;
  localparam int DEFAULT_M = 5;
  localparam int MAX_NREQ  = 8;
  localparam int ID_W      = 3;

  typedef logic [ID_W-1:0] req_id_t;

  // One entry of the read-latency pipeline: a read in flight and who issued it.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned nreq);
    return (idx + 1 >= nreq) ? 32'd0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_arbiter.sv
// Rotating-priority arbiter: grants the first valid requester at or after the
// pointer, and moves the pointer past the winner whenever a grant is taken.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] valid,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [IDW-1:0] ptr;
  logic           grant_any;

  function automatic logic [IDW-1:0] rot(input logic [IDW-1:0] base, input int off);
    return IDW'((int'(base) + off) % NREQ);
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_any && valid[rot(ptr, k)]) begin
        grant_any = 1'b1;
        grant_idx = rot(ptr, k);
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Pointer only moves on an accepted grant, so idle cycles keep the rotation position.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && grant_any) begin
      ptr <= IDW'(next_ptr(32'(grant_idx), NREQ));
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Shares one MemoryController between NREQ requesters: registers the granted
// command onto mem_* and routes read data back through an in-order latency pipe.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N      = DEFAULT_N,
  parameter int M      = DEFAULT_M,
  parameter int NREQ   = 2,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*M-1:0] req_addr,
  input  logic [NREQ*N-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [N-1:0]      rsp_rdata,
  output logic              mem_ctrl,
  output logic [M-1:0]      mem_addr,
  output logic [N-1:0]      mem_wdata,
  input  logic [N-1:0]      mem_rdata
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            accept;
  logic            sel_we;
  logic [M-1:0]    sel_addr;
  logic [N-1:0]    sel_wdata;

  rd_tag_t cmd_tag;
  rd_tag_t rd_pipe [RD_LAT];
  rd_tag_t rsp_tag;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .valid     (req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);

  always_comb begin
    sel_we    = req_we[grant_idx];
    sel_addr  = req_addr[int'(grant_idx)*M +: M];
    sel_wdata = req_wdata[int'(grant_idx)*N +: N];
  end

  // Idle cycles park the bus on a harmless read of address 0 so nothing is ever written by accident.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ctrl  <= MEM_READ;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cmd_tag   <= '0;
    end else if (accept) begin
      mem_ctrl      <= sel_we ? MEM_WRITE : MEM_READ;
      mem_addr      <= sel_addr;
      mem_wdata     <= sel_wdata;
      cmd_tag.valid <= ~sel_we;
      cmd_tag.id    <= req_id_t'(grant_idx);
    end else begin
      mem_ctrl  <= MEM_READ;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cmd_tag   <= '0;
    end
  end

  // cmd_tag marks a read on the bus; RD_LAT stages later its data sits on mem_rdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        rd_pipe[i] <= '0;
      end
    end else begin
      rd_pipe[0] <= cmd_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  assign rsp_tag   = rd_pipe[RD_LAT-1];
  assign rsp_rdata = mem_rdata;

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = rsp_tag.valid && (rsp_tag.id == req_id_t'(i));
    end
  end

endmodule
